// File: rtl/serialiser_unit_cell_pkg.sv
// Shared SERDES definitions: frame geometry, counter widths and the
// transmitter FSM encoding. The deserialiser imports this package too.
package serdes_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int FRAME_W   = WORD_W * NUM_WORDS;
  localparam int COUNT_W   = $clog2(WORD_W);
  localparam int SCNT_W    = $clog2(NUM_WORDS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serialiser_unit_cell_if.sv
// Bus bundle between a frame source and the serialiser.
// The master modport is the frame source; the slave modport is the serialiser.
interface serialiser_unit_cell_if;
  import serdes_pkg::*;

  logic               i_load;
  logic               i_abort;
  logic [FRAME_W-1:0] i_parIn;
  logic               o_serialOut;
  logic               o_ready;
  logic               o_busy;
  logic               o_complete;
  logic [COUNT_W-1:0] o_count;
  logic [SCNT_W-1:0]  o_sampleCount;

  modport master (
    output i_load, i_abort, i_parIn,
    input  o_serialOut, o_ready, o_busy, o_complete, o_count, o_sampleCount
  );

  modport slave (
    input  i_load, i_abort, i_parIn,
    output o_serialOut, o_ready, o_busy, o_complete, o_count, o_sampleCount
  );

endinterface

// File: rtl/serialiser_unit_cell_word_shifter.sv
// One word-wide load/shift-right register. Bit 0 is the bit currently on the line.
// Clear wins over load, load wins over shift.
module serialiser_word_shifter
  import serdes_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_lsb
);

  logic [WIDTH-1:0] r_word;

  // Hold the word being transmitted and move it one bit toward the LSB per shift.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_data;
    end else if (i_shift) begin
      r_word <= {1'b0, r_word[WIDTH-1:1]};
    end
  end

  assign o_lsb = r_word[0];

endmodule

// File: rtl/serialiser_unit_cell.sv
// Parallel-to-serial frame transmitter: word 1 first, LSB first, no gaps.
// An accepted LOAD spends one cycle in a pending phase (BUSY=1, READY=0) while
// the buffered word 1 is moved into the shifter, so the first bit appears one
// edge later and back-to-back frames are separated by two READY-low cycles.
module serialiser_unit_cell
  import serdes_pkg::*;
(
  input logic                   i_clk,
  input logic                   i_reset,
  serialiser_unit_cell_if.slave bus
);

  state_t             r_state, w_nextState;
  logic               r_pending, w_nextPending;
  logic               r_complete, w_nextComplete;
  logic [COUNT_W-1:0] r_count, w_nextCount;
  logic [SCNT_W-1:0]  r_sampleCount, w_nextSampleCount;
  logic [SCNT_W-1:0]  w_nextIdx;
  logic [FRAME_W-1:0] r_frame;
  logic [WORD_W-1:0]  w_shData;
  logic               w_capture, w_wordWrap, w_lastBit;
  logic               w_shLoad, w_shShift, w_shClear, w_serialBit;

  assign w_wordWrap = (r_count == COUNT_W'(WORD_W - 1));
  assign w_lastBit  = w_wordWrap && (r_sampleCount == SCNT_W'(NUM_WORDS - 1));
  assign w_nextIdx  = r_sampleCount + 1'b1;
  assign w_capture  = (r_state == IDLE) && !r_pending && bus.i_load && !bus.i_abort;

  // State, counters and the completion pulse register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_pending     <= 1'b0;
      r_complete    <= 1'b0;
      r_count       <= '0;
      r_sampleCount <= '0;
    end else begin
      r_state       <= w_nextState;
      r_pending     <= w_nextPending;
      r_complete    <= w_nextComplete;
      r_count       <= w_nextCount;
      r_sampleCount <= w_nextSampleCount;
    end
  end

  // Frame buffer: PAR_IN is captured once per accepted LOAD and never again mid-frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame <= '0;
    end else if (w_capture) begin
      r_frame <= bus.i_parIn;
    end
  end

  // Next-state logic and shifter control; ABORT beats a pending start and the frame end.
  always_comb begin
    w_nextState       = r_state;
    w_nextPending     = 1'b0;
    w_nextComplete    = 1'b0;
    w_nextCount       = r_count;
    w_nextSampleCount = r_sampleCount;
    w_shLoad          = 1'b0;
    w_shShift         = 1'b0;
    w_shClear         = 1'b0;
    w_shData          = r_frame[32'(w_nextIdx) * WORD_W +: WORD_W];
    case (r_state)
      IDLE: begin
        if (bus.i_abort) begin
          w_nextPending = 1'b0;
        end else if (r_pending) begin
          w_nextState       = SHIFT;
          w_shLoad          = 1'b1;
          w_shData          = r_frame[WORD_W-1:0];
          w_nextCount       = '0;
          w_nextSampleCount = '0;
        end else if (w_capture) begin
          w_nextPending = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.i_abort || w_lastBit) begin
          w_nextState       = IDLE;
          w_shClear         = 1'b1;
          w_nextCount       = '0;
          w_nextSampleCount = '0;
          w_nextComplete    = !bus.i_abort;
        end else if (w_wordWrap) begin
          w_shLoad          = 1'b1;
          w_nextCount       = '0;
          w_nextSampleCount = w_nextIdx;
        end else begin
          w_shShift   = 1'b1;
          w_nextCount = r_count + 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  serialiser_word_shifter #(
    .WIDTH (WORD_W)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_shClear),
    .i_load  (w_shLoad),
    .i_shift (w_shShift),
    .i_data  (w_shData),
    .o_lsb   (w_serialBit)
  );

  assign bus.o_serialOut   = w_serialBit;
  assign bus.o_ready       = (r_state == SHIFT);
  assign bus.o_busy        = (r_state == SHIFT) || r_pending;
  assign bus.o_complete    = r_complete;
  assign bus.o_count       = r_count;
  assign bus.o_sampleCount = r_sampleCount;

endmodule

// File: tb/tb_serialiser_unit_cell.sv
// Directed testbench for serialiser_unit_cell: full frames, back-to-back
// frames with held LOAD, mid-frame reset, ABORT and counter wrap points.
module tb_serialiser_unit_cell;
  import serdes_pkg::*;

  logic clk;
  logic reset;
  int   vectorsApplied;
  int   miscompares;

  logic [FRAME_W-1:0] frameA, frameB, frameC, frameD, rxFrame;

  serialiser_unit_cell_if bus ();

  serialiser_unit_cell dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic load, input logic abort);
    bus.i_load  = load;
    bus.i_abort = abort;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorsApplied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " serial"}, 32'(bus.o_serialOut), 32'd0);
    checkOutput({tag, " ready"}, 32'(bus.o_ready), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.o_busy), 32'd0);
    checkOutput({tag, " count"}, 32'(bus.o_count), 32'd0);
    checkOutput({tag, " sampleCount"}, 32'(bus.o_sampleCount), 32'd0);
  endtask

  // Samples bits 0..lastBit of a frame starting in the current cycle.
  task automatic receiveFrame(input int lastBit, input int changeAt,
                              input logic [FRAME_W-1:0] newPar,
                              output logic [FRAME_W-1:0] rx);
    rx = '0;
    for (int b = 0; b <= lastBit; b++) begin
      checkOutput($sformatf("ready@%0d", b), 32'(bus.o_ready), 32'd1);
      checkOutput($sformatf("count@%0d", b), 32'(bus.o_count), 32'(b % WORD_W));
      checkOutput($sformatf("sampleCount@%0d", b), 32'(bus.o_sampleCount), 32'(b / WORD_W));
      checkOutput($sformatf("complete@%0d", b), 32'(bus.o_complete), 32'd0);
      rx[b] = bus.o_serialOut;
      if (b == changeAt) bus.i_parIn = newPar;
      if (b != lastBit) tick();
    end
  endtask

  task automatic compareFrame(input string tag, input logic [FRAME_W-1:0] rx,
                              input logic [FRAME_W-1:0] exp);
    for (int w = 0; w < NUM_WORDS; w++) begin
      checkOutput($sformatf("%s word%0d", tag, w + 1), rx[w*WORD_W +: WORD_W], exp[w*WORD_W +: WORD_W]);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    vectorsApplied = 0;
    miscompares    = 0;
    for (int k = 1; k <= NUM_WORDS; k++) begin
      frameA[(k-1)*WORD_W +: WORD_W] = 32'hA5A5_0000 + 32'(k);
      frameB[(k-1)*WORD_W +: WORD_W] = 32'h3C3C_F000 - 32'(k);
      frameC[(k-1)*WORD_W +: WORD_W] = 32'h0000_0001 << (k - 1);
      frameD[(k-1)*WORD_W +: WORD_W] = 32'hDEAD_0000 + 32'(k) * 32'h1111;
    end

    reset = 1'b1;
    bus.i_parIn = '0;
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkIdle("reset");
    checkOutput("reset complete", 32'(bus.o_complete), 32'd0);
    reset = 1'b0;

    $display("[TB] step 1: single frame");
    bus.i_parIn = frameA;
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("accept busy", 32'(bus.o_busy), 32'd1);
    checkOutput("accept ready", 32'(bus.o_ready), 32'd0);
    checkOutput("accept serial", 32'(bus.o_serialOut), 32'd0);
    applyStimulus(1'b0, 1'b0);
    tick();
    receiveFrame(FRAME_W - 1, -1, '0, rxFrame);
    compareFrame("frameA", rxFrame, frameA);
    tick();
    checkIdle("end A");
    checkOutput("end A complete", 32'(bus.o_complete), 32'd1);
    tick();
    checkOutput("after A complete", 32'(bus.o_complete), 32'd0);
    checkOutput("after A busy", 32'(bus.o_busy), 32'd0);

    $display("[TB] step 3: LOAD held high, PAR_IN changed at bit 100");
    bus.i_parIn = frameA;
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    receiveFrame(FRAME_W - 1, 100, frameB, rxFrame);
    compareFrame("frame1", rxFrame, frameA);
    tick();
    checkOutput("gap1 ready", 32'(bus.o_ready), 32'd0);
    checkOutput("gap1 complete", 32'(bus.o_complete), 32'd1);
    checkOutput("gap1 busy", 32'(bus.o_busy), 32'd0);
    tick();
    checkOutput("gap2 ready", 32'(bus.o_ready), 32'd0);
    checkOutput("gap2 complete", 32'(bus.o_complete), 32'd0);
    checkOutput("gap2 busy", 32'(bus.o_busy), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0);
    receiveFrame(FRAME_W - 1, -1, '0, rxFrame);
    compareFrame("frame2", rxFrame, frameB);
    tick();
    checkOutput("end frame2 complete", 32'(bus.o_complete), 32'd1);
    tick();
    checkIdle("idle after frame2");

    $display("[TB] step 4: reset mid-frame at word 3 COUNT=5");
    bus.i_parIn = frameC;
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    receiveFrame(2 * WORD_W + 5, -1, '0, rxFrame);
    compareFrame("frameC partial", rxFrame & ((FRAME_W'(1) << 70) - 1),
                 frameC & ((FRAME_W'(1) << 70) - 1));
    reset = 1'b1;
    tick();
    checkIdle("mid reset");
    checkOutput("mid reset complete", 32'(bus.o_complete), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("post reset complete", 32'(bus.o_complete), 32'd0);
    bus.i_parIn = frameD;
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("restart bit0", 32'(bus.o_serialOut), 32'(frameD[0]));

    $display("[TB] step 5: ABORT at bit 255, then ABORT+LOAD in idle");
    receiveFrame(FRAME_W - 1, -1, '0, rxFrame);
    compareFrame("frameD", rxFrame, frameD);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkIdle("abort");
    checkOutput("abort complete", 32'(bus.o_complete), 32'd0);
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("abort+load complete", 32'(bus.o_complete), 32'd0);
    checkOutput("abort+load busy", 32'(bus.o_busy), 32'd0);
    tick();
    checkIdle("abort+load hold");
    applyStimulus(1'b0, 1'b0);
    tick();
    checkIdle("final idle");
    checkOutput("final complete", 32'(bus.o_complete), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
